// File: rtl/execute_stage_pipelined.sv
// -----------------------------------------------------------------------------
// execute_stage_pipelined
//   Execute stage of the 5-stage RISC-V pipeline, between the D/E and E/M
//   boundaries. Contains the operand forwarding muxes, the RV32I ALU, the
//   branch comparator, JAL/JALR target generation, an optional iterative
//   shift-add multiplier, and the E/M pipeline register.
//
// Ports
//   clk, rst            clock (rising edge) and asynchronous active-low reset
//   *E controls         decoded controls from the D/E register
//   RD1_E, RD2_E        register-file operands
//   Imm_Ext_E           sign-extended immediate
//   PCE, PCPlus4E       PC of the instruction in E and its PC+4
//   RD_E                destination register index
//   ForwardAE/BE        forwarding selects (00 RF, 01 ResultW, 10 ALU_ResultM)
//   ResultW             writeback-stage forward value
//   StallM, FlushM      E/M register hold / bubble insertion
//   PCSrcE, PCTargetE   fetch redirect request and target
//   BusyE               multiplier occupying E (hazard unit stalls F/D/E)
//   *M outputs          E/M pipeline register contents
// -----------------------------------------------------------------------------
module execute_stage_pipelined #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REGW   = 5,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic            ALUSrcE,
    input  logic            BranchE,
    input  logic            JumpE,
    input  logic            JalrE,
    input  logic            MulE,
    input  logic [1:0]      ResultSrcE,
    input  logic [2:0]      BranchTypeE,
    input  logic [3:0]      ALUControlE,
    input  logic [XLEN-1:0] RD1_E,
    input  logic [XLEN-1:0] RD2_E,
    input  logic [XLEN-1:0] Imm_Ext_E,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [REGW-1:0] RD_E,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
    input  logic            StallM,
    input  logic            FlushM,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            BusyE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic [1:0]      ResultSrcM,
    output logic [REGW-1:0] RD_M,
    output logic [XLEN-1:0] PCPlus4M,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] ALU_ResultM
);

    localparam int unsigned SHW = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mul_state_t;

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] result_e;
    logic [XLEN-1:0] jalr_sum;
    logic [SHW-1:0]  shamt;
    logic            taken;
    logic            busy;
    logic            mul_busy;
    logic            mul_done;
    logic [XLEN-1:0] mul_product;

    // ---------------- operand forwarding ----------------
    always_comb begin
        case (ForwardAE)
            2'b01:   src_a = ResultW;
            2'b10:   src_a = ALU_ResultM;
            default: src_a = RD1_E;
        endcase
        case (ForwardBE)
            2'b01:   fwd_b = ResultW;
            2'b10:   fwd_b = ALU_ResultM;
            default: fwd_b = RD2_E;
        endcase
    end

    assign src_b = ALUSrcE ? Imm_Ext_E : fwd_b;
    assign shamt = src_b[SHW-1:0];

    // ---------------- ALU ----------------
    always_comb begin
        alu_result = '0;
        case (ALUControlE)
            4'd0: alu_result = src_a + src_b;
            4'd1: alu_result = src_a - src_b;
            4'd2: alu_result = src_a & src_b;
            4'd3: alu_result = src_a | src_b;
            4'd4: alu_result = src_a ^ src_b;
            4'd5: alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            4'd6: alu_result = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            4'd7: alu_result = src_a << shamt;
            4'd8: alu_result = src_a >> shamt;
            4'd9: alu_result = $signed(src_a) >>> shamt;
            default: alu_result = '0;
        endcase
    end

    // ---------------- branch / jump ----------------
    always_comb begin
        taken = 1'b0;
        case (BranchTypeE)
            3'b000:  taken = (src_a == fwd_b);
            3'b001:  taken = (src_a != fwd_b);
            3'b100:  taken = ($signed(src_a) <  $signed(fwd_b));
            3'b101:  taken = ($signed(src_a) >= $signed(fwd_b));
            3'b110:  taken = (src_a <  fwd_b);
            3'b111:  taken = (src_a >= fwd_b);
            default: taken = 1'b0;
        endcase
    end

    assign jalr_sum  = src_a + Imm_Ext_E;
    assign PCTargetE = JalrE ? (jalr_sum & {{(XLEN-1){1'b1}}, 1'b0}) : (PCE + Imm_Ext_E);
    // No redirect while in reset or while the multiplier owns the stage.
    assign PCSrcE    = rst & ~busy & ((BranchE & taken) | JumpE);

    // ---------------- multiplier ----------------
    generate
        if (MUL_EN) begin : g_mul
            mul_state_t      state;
            mul_state_t      state_next;
            logic [XLEN-1:0] acc;
            logic [XLEN-1:0] mcand;
            logic [XLEN-1:0] mplier;
            logic [SHW-1:0]  cnt;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) state <= IDLE;
                else      state <= state_next;
            end

            always_comb begin
                state_next = state;
                case (state)
                    IDLE:    if (MulE) state_next = RUN;
                    RUN:     if (cnt == SHW'(XLEN-1)) state_next = DONE;
                    DONE:    if (!StallM) state_next = IDLE;
                    default: state_next = IDLE;
                endcase
            end

            always_comb begin
                mul_busy = 1'b0;
                mul_done = 1'b0;
                case (state)
                    IDLE:    mul_busy = MulE;
                    RUN:     mul_busy = 1'b1;
                    DONE:    mul_done = 1'b1;
                    default: mul_busy = 1'b0;
                endcase
            end

            // One multiplicand bit per cycle; the multiplier is shifted left
            // alongside so only the low XLEN product bits are ever kept.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    acc    <= '0;
                    mcand  <= '0;
                    mplier <= '0;
                    cnt    <= '0;
                end else begin
                    case (state)
                        IDLE: begin
                            if (MulE) begin
                                acc    <= '0;
                                cnt    <= '0;
                                mcand  <= src_a;
                                mplier <= src_b;
                            end
                        end
                        RUN: begin
                            if (mcand[0]) acc <= acc + mplier;
                            mcand  <= mcand >> 1;
                            mplier <= mplier << 1;
                            cnt    <= cnt + SHW'(1);
                        end
                        default: ;
                    endcase
                end
            end

            assign mul_product = acc;
        end else begin : g_nomul
            assign mul_busy    = 1'b0;
            assign mul_done    = 1'b0;
            assign mul_product = '0;
        end
    endgenerate

    assign busy     = rst & mul_busy;
    assign BusyE    = busy;
    assign result_e = mul_done ? mul_product : alu_result;

    // ---------------- E/M register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteM   <= 1'b0;
            MemWriteM   <= 1'b0;
            ResultSrcM  <= 2'b00;
            RD_M        <= '0;
            PCPlus4M    <= '0;
            WriteDataM  <= '0;
            ALU_ResultM <= '0;
        end else if (!StallM) begin
            if (FlushM || busy) begin
                RegWriteM   <= 1'b0;
                MemWriteM   <= 1'b0;
                ResultSrcM  <= 2'b00;
                RD_M        <= '0;
                PCPlus4M    <= '0;
                WriteDataM  <= '0;
                ALU_ResultM <= '0;
            end else begin
                RegWriteM   <= RegWriteE;
                MemWriteM   <= MemWriteE;
                ResultSrcM  <= ResultSrcE;
                RD_M        <= RD_E;
                PCPlus4M    <= PCPlus4E;
                WriteDataM  <= fwd_b;
                ALU_ResultM <= result_e;
            end
        end
    end

endmodule

// File: tb/tb_execute_stage_pipelined.sv
// -----------------------------------------------------------------------------
// tb_execute_stage_pipelined
//   Self-checking bench for execute_stage_pipelined (XLEN=32, MUL_EN=1).
//   A behavioural model computes forwarding, ALU, branch and E/M contents
//   from the instruction-level rules; directed steps cover the named
//   scenarios, followed by a randomized ALU/branch run and multiplies.
// -----------------------------------------------------------------------------
module tb_execute_stage_pipelined;

    localparam int XLEN = 32;
    localparam int REGW = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, JalrE, MulE;
    logic [1:0]      ResultSrcE;
    logic [2:0]      BranchTypeE;
    logic [3:0]      ALUControlE;
    logic [XLEN-1:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
    logic [REGW-1:0] RD_E;
    logic [1:0]      ForwardAE, ForwardBE;
    logic [XLEN-1:0] ResultW;
    logic            StallM, FlushM;
    logic            PCSrcE;
    logic [XLEN-1:0] PCTargetE;
    logic            BusyE;
    logic            RegWriteM, MemWriteM;
    logic [1:0]      ResultSrcM;
    logic [REGW-1:0] RD_M;
    logic [XLEN-1:0] PCPlus4M, WriteDataM, ALU_ResultM;

    int checks = 0;
    int errors = 0;

    // model of the E/M register contents
    logic            exp_regw, exp_memw;
    logic [1:0]      exp_rs;
    logic [REGW-1:0] exp_rd;
    logic [31:0]     exp_pc4, exp_wd, exp_alu;

    always #5 clk = ~clk;

    execute_stage_pipelined #(
        .XLEN  (XLEN),
        .REGW  (REGW),
        .MUL_EN(1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .RegWriteE  (RegWriteE),
        .MemWriteE  (MemWriteE),
        .ALUSrcE    (ALUSrcE),
        .BranchE    (BranchE),
        .JumpE      (JumpE),
        .JalrE      (JalrE),
        .MulE       (MulE),
        .ResultSrcE (ResultSrcE),
        .BranchTypeE(BranchTypeE),
        .ALUControlE(ALUControlE),
        .RD1_E      (RD1_E),
        .RD2_E      (RD2_E),
        .Imm_Ext_E  (Imm_Ext_E),
        .PCE        (PCE),
        .PCPlus4E   (PCPlus4E),
        .RD_E       (RD_E),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .ResultW    (ResultW),
        .StallM     (StallM),
        .FlushM     (FlushM),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .BusyE      (BusyE),
        .RegWriteM  (RegWriteM),
        .MemWriteM  (MemWriteM),
        .ResultSrcM (ResultSrcM),
        .RD_M       (RD_M),
        .PCPlus4M   (PCPlus4M),
        .WriteDataM (WriteDataM),
        .ALU_ResultM(ALU_ResultM)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] rf);
        if (sel == 2'b01) return ResultW;
        if (sel == 2'b10) return exp_alu;
        return rf;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd6: return (a < b) ? 32'd1 : 32'd0;
            4'd7: return a << sh;
            4'd8: return a >> sh;
            4'd9: return a[31] ? ~((~a) >> sh) : (a >> sh);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_taken(input logic [2:0] bt, input logic [31:0] a,
                                       input logic [31:0] b);
        case (bt)
            3'b000: return a == b;
            3'b001: return a != b;
            3'b100: return int'(a) <  int'(b);
            3'b101: return int'(a) >= int'(b);
            3'b110: return a <  b;
            3'b111: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_zero();
        exp_regw = 0; exp_memw = 0; exp_rs = 0; exp_rd = 0;
        exp_pc4 = 0; exp_wd = 0; exp_alu = 0;
    endtask

    task automatic model_load(input logic [31:0] result);
        logic [31:0] wd;
        wd = ref_fwd(ForwardBE, RD2_E);
        exp_regw = RegWriteE; exp_memw = MemWriteE; exp_rs = ResultSrcE; exp_rd = RD_E;
        exp_pc4 = PCPlus4E; exp_wd = wd; exp_alu = result;
    endtask

    task automatic check_m(input string tag);
        chk({tag, ".RegWriteM"},   RegWriteM,   exp_regw);
        chk({tag, ".MemWriteM"},   MemWriteM,   exp_memw);
        chk({tag, ".ResultSrcM"},  ResultSrcM,  exp_rs);
        chk({tag, ".RD_M"},        RD_M,        exp_rd);
        chk({tag, ".PCPlus4M"},    PCPlus4M,    exp_pc4);
        chk({tag, ".WriteDataM"},  WriteDataM,  exp_wd);
        chk({tag, ".ALU_ResultM"}, ALU_ResultM, exp_alu);
    endtask

    // Called with inputs driven shortly after a rising edge: checks the
    // combinational redirect, advances the model, clocks, checks E/M.
    task automatic cycle_check(input string tag);
        logic [31:0] a, fb, sb, tgt;
        logic        pcs;
        #1;
        a   = ref_fwd(ForwardAE, RD1_E);
        fb  = ref_fwd(ForwardBE, RD2_E);
        sb  = ALUSrcE ? Imm_Ext_E : fb;
        pcs = (BranchE && ref_taken(BranchTypeE, a, fb)) || JumpE;
        tgt = JalrE ? ((a + Imm_Ext_E) & 32'hFFFF_FFFE) : (PCE + Imm_Ext_E);
        chk({tag, ".PCSrcE"},    PCSrcE,    pcs);
        chk({tag, ".PCTargetE"}, PCTargetE, tgt);
        chk({tag, ".BusyE"},     BusyE,     1'b0);
        if (!StallM) begin
            if (FlushM) model_zero();
            else        model_load(ref_alu(ALUControlE, a, sb));
        end
        @(posedge clk); #1;
        check_m(tag);
    endtask

    task automatic drive_idle();
        RegWriteE = 0; MemWriteE = 0; ALUSrcE = 0; BranchE = 0; JumpE = 0; JalrE = 0;
        MulE = 0; ResultSrcE = 0; BranchTypeE = 0; ALUControlE = 0;
        RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; PCE = 0; PCPlus4E = 0; RD_E = 0;
        ForwardAE = 0; ForwardBE = 0; ResultW = 0; StallM = 0; FlushM = 0;
    endtask

    initial begin
        int          busy_n;
        logic [31:0] ma, mb;

        // ---- reset state ----
        rst = 1'b0;
        drive_idle();
        JumpE = 1'b1;
        model_zero();
        #12;
        check_m("reset");
        chk("reset.BusyE",  BusyE,  1'b0);
        chk("reset.PCSrcE", PCSrcE, 1'b0);
        JumpE = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;

        // ---- seed ALU_ResultM = 7 ----
        RD1_E = 7; RD2_E = 0; RegWriteE = 1; RD_E = 3; PCPlus4E = 32'h4;
        cycle_check("seed");
        chk("seed.alu7", ALU_ResultM, 32'd7);

        // ---- ADD with forwarding from M ----
        RD1_E = 5; RD2_E = 32'h99; ForwardBE = 2'b10; RD_E = 4; PCPlus4E = 32'h8;
        cycle_check("addfwd");
        chk("addfwd.alu12", ALU_ResultM, 32'd12);
        chk("addfwd.wd7",   WriteDataM,  32'd7);

        // ---- BLTU vs BLT ----
        ForwardBE = 2'b00; RD1_E = 32'hFFFF_FFFF; RD2_E = 32'd1; RegWriteE = 0;
        BranchE = 1; BranchTypeE = 3'b110; PCE = 32'h100; Imm_Ext_E = 32'h20;
        #1;
        chk("bltu.pcsrc", PCSrcE, 1'b0);
        cycle_check("bltu");
        BranchTypeE = 3'b100;
        #1;
        chk("blt.pcsrc",  PCSrcE,    1'b1);
        chk("blt.target", PCTargetE, 32'h120);
        cycle_check("blt");

        // ---- JALR ----
        BranchE = 0; JumpE = 1; JalrE = 1; RD1_E = 32'h1003; Imm_Ext_E = 32'h4;
        PCPlus4E = 32'h104; ResultSrcE = 2'b10; RegWriteE = 1; RD_E = 1;
        #1;
        chk("jalr.pcsrc",  PCSrcE,    1'b1);
        chk("jalr.target", PCTargetE, 32'h1006);
        cycle_check("jalr");
        chk("jalr.pc4m", PCPlus4M, 32'h104);

        // ---- StallM + FlushM together hold; FlushM alone bubbles ----
        JumpE = 0; JalrE = 0; ResultSrcE = 0; RD_E = 9; PCPlus4E = 32'h300;
        StallM = 1; FlushM = 1;
        cycle_check("stallflush");
        chk("stallflush.rd_hold",  RD_M,     5'd1);
        chk("stallflush.pc4_hold", PCPlus4M, 32'h104);
        StallM = 0;
        cycle_check("flush");
        chk("flush.regw", RegWriteM, 1'b0);
        chk("flush.rd",   RD_M,      5'd0);
        FlushM = 0;

        // ---- randomized ALU / branch / jump traffic ----
        for (int i = 0; i < 150; i++) begin
            RegWriteE   = 1'($urandom);
            MemWriteE   = 1'($urandom);
            ALUSrcE     = 1'($urandom);
            BranchE     = 1'($urandom);
            JumpE       = ($urandom_range(0, 5) == 0);
            JalrE       = 1'($urandom);
            ResultSrcE  = 2'($urandom);
            BranchTypeE = 3'($urandom);
            ALUControlE = 4'($urandom);
            RD1_E       = ($urandom_range(0, 3) == 0) ? RD2_E : $urandom;
            RD2_E       = $urandom;
            Imm_Ext_E   = $urandom;
            PCE         = $urandom;
            PCPlus4E    = PCE + 32'd4;
            RD_E        = 5'($urandom);
            ForwardAE   = 2'($urandom);
            ForwardBE   = 2'($urandom);
            ResultW     = $urandom;
            StallM      = ($urandom_range(0, 7) == 0);
            FlushM      = ($urandom_range(0, 7) == 0);
            cycle_check("rand");
        end

        // ---- multiply 0xFFFFFFFF * 3 ----
        drive_idle();
        RD1_E = 32'hFFFF_FFFF; RD2_E = 32'd3; MulE = 1; RegWriteE = 1; RD_E = 7;
        PCPlus4E = 32'h200;
        #1;
        chk("mul1.busy_first", BusyE,  1'b1);
        chk("mul1.pcsrc_busy", PCSrcE, 1'b0);
        busy_n = 1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (!BusyE) break;
            busy_n++;
            chk("mul1.bubble_regw", RegWriteM,   1'b0);
            chk("mul1.bubble_alu",  ALU_ResultM, 32'd0);
        end
        chk("mul1.busy_cycles", busy_n, 33);
        model_zero();
        check_m("mul1.done_bubble");
        model_load(32'hFFFF_FFFD);
        @(posedge clk); #1;
        MulE = 0;
        check_m("mul1.capture");
        chk("mul1.result", ALU_ResultM, 32'hFFFF_FFFD);
        chk("mul1.regw",   RegWriteM,   1'b1);

        // ---- random multiply with StallM held in DONE ----
        ma = $urandom; mb = $urandom;
        RD1_E = ma; ALUSrcE = 1; Imm_Ext_E = mb; MulE = 1; RD_E = 11; RD2_E = $urandom;
        busy_n = 1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (!BusyE) break;
            busy_n++;
        end
        chk("mul2.busy_cycles", busy_n, 33);
        model_zero();
        check_m("mul2.done_bubble");
        StallM = 1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("mul2.stall_busy", BusyE, 1'b0);
            check_m("mul2.stall_hold");
        end
        StallM = 0;
        model_load(ma * mb);
        @(posedge clk); #1;
        MulE = 0;
        check_m("mul2.capture");
        #1;
        chk("mul2.idle_after", BusyE, 1'b0);

        // ---- reset in the middle of a multiply ----
        drive_idle();
        @(posedge clk); #1;
        RD1_E = $urandom; RD2_E = $urandom; MulE = 1; RegWriteE = 1; RD_E = 2;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
        end
        chk("rstmul.busy_before", BusyE, 1'b1);
        rst = 1'b0; JumpE = 1'b1;
        #1;
        model_zero();
        check_m("rstmul");
        chk("rstmul.BusyE",  BusyE,  1'b0);
        chk("rstmul.PCSrcE", PCSrcE, 1'b0);
        @(negedge clk);
        rst = 1'b1; MulE = 0; JumpE = 0;
        @(posedge clk); #1;
        RD1_E = 32'd100; RD2_E = 32'd23; ALUControlE = 0; RD_E = 6; PCPlus4E = 32'h44;
        cycle_check("postrst_add");
        chk("postrst_add.result", ALU_ResultM, 32'd123);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
